audio_pdm_sink: RTL

Consumer end of the 16-bit audio sample interface driven by the top-level design's audio_out.
- Accepts samples over a valid/ready handshake into a small FIFO.
- Pops one sample per programmable sample period.
- Converts the current sample to a 1-bit pulse-density stream with a first-order sigma-delta modulator.
- pdm_out drives a single pin through an external RC filter or speaker.

---
 rtl/audio_pkg.sv | 13 +
 rtl/audio_sample_fifo.sv | 53 +++++
 rtl/audio_pdm_sink.sv | 94 +++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types and offset conversion
package audio_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [SAMPLE_W-1:0] sample_t;

  // Two's complement to offset binary: flipping the MSB maps -FS..+FS onto 0..2^W-1.
  function automatic sample_t to_unsigned(input sample_t s, input logic is_signed);
    return is_signed ? {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]} : s;
  endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// rtl/audio_sample_fifo.sv - synchronous sample FIFO with occupancy level
module audio_sample_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  import audio_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  // Gated on registered flags, so a pop while full never frees room for a same-cycle push.
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level <= level + (AW+1)'(1);
        2'b01:   level <= level - (AW+1)'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/audio_pdm_sink.sv
// rtl/audio_pdm_sink.sv - buffered audio sink with sample-rate divider and 1st-order sigma-delta PDM output
module audio_pdm_sink #(
  parameter int SAMPLE_W   = 16,
  parameter int DIV_W      = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SAMPLE_W-1:0]           sample_in,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic [DIV_W-1:0]              div,
  input  logic                          signed_mode,
  input  logic                          enable,
  output logic                          pdm_out,
  output logic                          sample_strobe,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  import audio_pkg::*;

  logic [DIV_W-1:0]    count;
  logic                tick;
  logic                fifo_full;
  logic                fifo_empty;
  logic [SAMPLE_W-1:0] head;
  logic [SAMPLE_W-1:0] cur_sample;
  logic [SAMPLE_W-1:0] u;
  logic [SAMPLE_W-1:0] acc;
  logic [SAMPLE_W:0]   sum;

  audio_sample_fifo #(
    .W     (SAMPLE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (sample_valid),
    .push_data (sample_in),
    .pop       (tick),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign sample_ready = !fifo_full;
  assign tick         = enable && (count == div);

  // A count stranded above a freshly lowered div restarts without ticking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)               count <= '0;
    else if (!enable)      count <= '0;
    else if (count >= div) count <= '0;
    else                   count <= count + DIV_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_sample    <= '0;
      sample_strobe <= 1'b0;
      underrun      <= 1'b0;
    end else begin
      sample_strobe <= tick && !fifo_empty;
      underrun      <= tick && fifo_empty;
      if (tick && !fifo_empty) cur_sample <= head;
    end
  end

  generate
    if (SAMPLE_W == audio_pkg::SAMPLE_W) begin : g_pkg_conv
      assign u = to_unsigned(cur_sample, signed_mode);
    end else begin : g_local_conv
      assign u = signed_mode ? {~cur_sample[SAMPLE_W-1], cur_sample[SAMPLE_W-2:0]} : cur_sample;
    end
  endgenerate

  // The carry out of the accumulator is the pulse; its density equals u / 2^SAMPLE_W.
  assign sum = {1'b0, acc} + {1'b0, u};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc     <= '0;
      pdm_out <= 1'b0;
    end else if (!enable) begin
      acc     <= '0;
      pdm_out <= 1'b0;
    end else begin
      acc     <= sum[SAMPLE_W-1:0];
      pdm_out <= sum[SAMPLE_W];
    end
  end

endmodule
